// File: rtl/icache_line_fill_pkg.sv
// Shared types and width helpers for the Icache line-fill engine.
// Holds the FSM encoding, the AXI RRESP encoding and line geometry helpers.
package icache_line_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RESP = 2'd3
  } fill_state_e;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

  function automatic int cache_width_f(
    input int dw,
    input int bs
  );
    return dw * bs;
  endfunction

  function automatic int offset_width_f(
    input int dw,
    input int bs
  );
    return $clog2((dw * bs) / 8);
  endfunction

  function automatic int cnt_width_f(
    input int beats
  );
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/icache_line_fill.sv
// Icache refill engine: one line request in, one INCR burst read out,
// beats assembled into a full line returned with a one-cycle valid pulse.
// Ports:
//   CLK, RST                     clock, sync active-high reset
//   ADDR_TO_L2(_VALID)           miss line address + strobe
//   DATA_FROM_L2(_VALID)         assembled line + one-cycle pulse
//   FILL_BUSY, FILL_ERR          fill in flight / sticky error of last fill
//   M_AR*                        burst read address channel
//   M_R*                         burst read data channel
module icache_line_fill
  import icache_line_fill_pkg::*;
#(
  parameter int data_width     = 32,
  parameter int address_width  = 32,
  parameter int block_size     = 32,
  parameter int mem_data_width = 32,
  localparam int cache_width   =
    cache_width_f(data_width, block_size),
  localparam int offset_width  =
    offset_width_f(data_width, block_size)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ADDR_TO_L2_VALID,
  input  logic [address_width-offset_width-1:0]
                                 ADDR_TO_L2,
  output logic [cache_width-1:0] DATA_FROM_L2,
  output logic                   DATA_FROM_L2_VALID,
  output logic                   FILL_BUSY,
  output logic                   FILL_ERR,
  output logic [address_width-1:0]
                                 M_ARADDR,
  output logic [7:0]             M_ARLEN,
  output logic                   M_ARVALID,
  input  logic                   M_ARREADY,
  input  logic [mem_data_width-1:0]
                                 M_RDATA,
  input  logic [1:0]             M_RRESP,
  input  logic                   M_RLAST,
  input  logic                   M_RVALID,
  output logic                   M_RREADY
);

  localparam int BEATS = cache_width / mem_data_width;
  localparam int BW    = cnt_width_f(BEATS);
  localparam int LW    = address_width - offset_width;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [7:0]    ARLEN_C   = 8'(BEATS - 1);

  fill_state_e r_state;
  fill_state_e w_next;

  logic [LW-1:0]             r_addr;
  logic [BW-1:0]             r_cnt;
  logic                      r_err;
  logic [mem_data_width-1:0] r_buf [BEATS];

  logic w_req;
  logic w_beat;
  logic w_last;

  assign w_req  = (r_state == ST_IDLE)
                & ADDR_TO_L2_VALID;
  assign w_beat = (r_state == ST_R) & M_RVALID;
  // The local counter, not RLAST, decides
  // which beat completes the line.
  assign w_last = (r_cnt == LAST_BEAT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (ADDR_TO_L2_VALID) w_next = ST_AR;
      end
      ST_AR: begin
        if (M_ARREADY) w_next = ST_R;
      end
      ST_R: begin
        if (M_RVALID && w_last) w_next = ST_RESP;
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    M_ARVALID          = 1'b0;
    M_ARLEN            = '0;
    M_RREADY           = 1'b0;
    DATA_FROM_L2_VALID = 1'b0;
    FILL_BUSY          = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        FILL_BUSY = 1'b0;
      end
      ST_AR: begin
        M_ARVALID = 1'b1;
        M_ARLEN   = ARLEN_C;
      end
      ST_R: begin
        M_RREADY = 1'b1;
      end
      ST_RESP: begin
        DATA_FROM_L2_VALID = 1'b1;
      end
      default: begin
        FILL_BUSY = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      for (int i = 0; i < BEATS; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      if (w_req) begin
        r_addr <= ADDR_TO_L2;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end
      if (w_beat) begin
        r_buf[r_cnt] <= M_RDATA;
        r_cnt <= w_last ? '0 : r_cnt + BW'(1);
        // A bad response or a misplaced RLAST
        // flags the line but never stops assembly.
        r_err <= r_err
               | (M_RRESP != RRESP_OKAY)
               | (M_RLAST != w_last);
      end
    end
  end

  assign M_ARADDR = {r_addr, {offset_width{1'b0}}};
  assign FILL_ERR = r_err;

  for (genvar g = 0; g < BEATS; g++) begin : g_pack
    assign DATA_FROM_L2[g*mem_data_width +: mem_data_width]
      = r_buf[g];
  end

endmodule
